// File: rtl/timer_tick_counter_if.sv
// Purpose : tick/config/status bundle between the tick source, the config
//           writer and timer_tick_counter.
// Signals : AClkHEn clock enable, ATick tick pulse, ACfgWr/ACfgReload/ACfgRun/
//           ACfgPeriodic config write, AIrqAck irq clear (driven by master);
//           ACount, AIrq, AOverrun, ARunning status (driven by the timer).
interface timer_tick_counter_if #(
  parameter int unsigned CCntW = 16
) ();

  logic             AClkHEn;
  logic             ATick;
  logic             ACfgWr;
  logic [CCntW-1:0] ACfgReload;
  logic             ACfgRun;
  logic             ACfgPeriodic;
  logic             AIrqAck;
  logic [CCntW-1:0] ACount;
  logic             AIrq;
  logic             AOverrun;
  logic             ARunning;

  // Tick source / config writer side
  modport master (
    output AClkHEn, ATick, ACfgWr, ACfgReload, ACfgRun, ACfgPeriodic, AIrqAck,
    input  ACount, AIrq, AOverrun, ARunning
  );

  // Timer side
  modport slave (
    input  AClkHEn, ATick, ACfgWr, ACfgReload, ACfgRun, ACfgPeriodic, AIrqAck,
    output ACount, AIrq, AOverrun, ARunning
  );

endinterface

// File: rtl/timer_tick_counter.sv
// Purpose : programmable interval timer. Counts upstream tick pulses down from
//           a reload value and raises a sticky interrupt on expiry, in
//           one-shot or periodic mode.
// Ports   : AClkH    - system clock
//           AResetHN - asynchronous active-low reset
//           bus      - timer_tick_counter_if.slave (enable, tick, config write,
//                      irq ack in; count, irq, overrun, running out)
// The interface instance must be built with the same CCntW as this module.
module timer_tick_counter #(
  parameter int unsigned      CCntW       = 16,
  parameter logic [CCntW-1:0] CReloadInit = CCntW'(16'h00FF)
) (
  input  logic                 AClkH,
  input  logic                 AResetHN,
  timer_tick_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CCntW-1:0] count;
  logic [CCntW-1:0] reload;
  logic             periodic;
  logic             irq;
  logic             overrun;
  logic             running;

  logic             tick_run_c;
  logic             count_zero_c;
  logic             expire_c;

  // A config write discards any tick in the same cycle, so no expiry then.
  assign tick_run_c   = bus.ATick && !bus.ACfgWr && (state == RUN);
  assign count_zero_c = ~(|count);
  assign expire_c     = tick_run_c && count_zero_c;

  // State, counter, configuration and flags; everything frozen while disabled.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= CReloadInit;
      periodic <= 1'b0;
      irq      <= 1'b0;
      overrun  <= 1'b0;
      running  <= 1'b0;
    end else if (bus.AClkHEn) begin
      if (bus.ACfgWr) begin
        reload   <= bus.ACfgReload;
        periodic <= bus.ACfgPeriodic;
        count    <= bus.ACfgReload;
        state    <= bus.ACfgRun ? RUN : IDLE;
        running  <= bus.ACfgRun;
      end else if (tick_run_c) begin
        if (!count_zero_c) begin
          count <= count - CCntW'(1);
        end else if (periodic) begin
          count <= reload;
        end else begin
          state   <= DONE;
          running <= 1'b0;
        end
      end

      // Expiry beats an ack on the irq flag.
      if (expire_c) begin
        irq <= 1'b1;
      end else if (bus.AIrqAck) begin
        irq <= 1'b0;
      end

      // An ack in the expiry cycle retires the pending irq, so no overrun.
      if (bus.AIrqAck) begin
        overrun <= 1'b0;
      end else if (expire_c && irq) begin
        overrun <= 1'b1;
      end
    end
  end

  assign bus.ACount   = count;
  assign bus.AIrq     = irq;
  assign bus.AOverrun = overrun;
  assign bus.ARunning = running;

endmodule

// File: tb/tb_timer_tick_counter.sv
module tb_timer_tick_counter;

  localparam int unsigned W = 16;

  typedef struct {
    logic         tick;
    logic         wr;
    logic [W-1:0] reload;
    logic         run;
    logic         per;
    logic         ack;
    logic         en;
    logic [W-1:0] e_cnt;
    logic         e_irq;
    logic         e_ovr;
    logic         e_run;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  timer_tick_counter_if #(.CCntW(W)) bus ();

  timer_tick_counter #(.CCntW(W), .CReloadInit(16'h00FF)) dut (
    .AClkH   (clk),
    .AResetHN(rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic tick, logic wr, logic [W-1:0] reload,
                              logic run, logic per, logic ack, logic en,
                              logic [W-1:0] e_cnt, logic e_irq, logic e_ovr,
                              logic e_run);
    vec_t v;
    v.tick = tick; v.wr = wr; v.reload = reload; v.run = run; v.per = per;
    v.ack = ack; v.en = en; v.e_cnt = e_cnt; v.e_irq = e_irq;
    v.e_ovr = e_ovr; v.e_run = e_run;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic [W-1:0] cnt, logic irq,
                               logic ovr, logic run);
    chk({tag, " ACount"},   32'(bus.ACount),   32'(cnt));
    chk({tag, " AIrq"},     32'(bus.AIrq),     32'(irq));
    chk({tag, " AOverrun"}, 32'(bus.AOverrun), 32'(ovr));
    chk({tag, " ARunning"}, 32'(bus.ARunning), 32'(run));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    bus.ATick        = v.tick;
    bus.ACfgWr       = v.wr;
    bus.ACfgReload   = v.reload;
    bus.ACfgRun      = v.run;
    bus.ACfgPeriodic = v.per;
    bus.AIrqAck      = v.ack;
    bus.AClkHEn      = v.en;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.e_cnt, e.e_irq, e.e_ovr, e.e_run);
    end
  endtask

  initial begin
    // Reset then 5 ticks: nothing moves while IDLE
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0));
    // One-shot reload 0xFF
    vecs.push_back(mk(0,1,16'h00FF,1,0,0,1, 16'h00FF,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 16'h00FE,0,0,1));
    // One-shot reload 3: 3,2,1,0 then expiry on the 4th tick
    vecs.push_back(mk(0,1,3,1,0,0,1, 3,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 2,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 2,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
    // Periodic reload 2, 9 ticks without ack
    vecs.push_back(mk(0,1,2,1,1,0,1, 2,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 2,1,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,1,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 2,1,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,1,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 2,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1,1, 2,0,0,1));
    // Periodic reload 0: expiry every tick; ack coinciding with expiry
    vecs.push_back(mk(0,1,0,1,1,0,1, 0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,0,1));
    vecs.push_back(mk(1,0,0,0,0,1,1, 0,1,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,1,1,1));
    vecs.push_back(mk(1,0,0,0,0,1,1, 0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0,1));
    // Config write beats a tick at ACount=1: reload 5, no expiry
    vecs.push_back(mk(0,1,1,1,0,0,1, 1,0,0,1));
    vecs.push_back(mk(1,1,5,1,0,0,1, 5,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 4,0,0,1));
    // Enable low freezes everything, then stop at 7
    vecs.push_back(mk(0,1,9,1,0,0,1, 9,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 8,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1, 7,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 7,0,0,1));
    vecs.push_back(mk(1,1,3,0,0,0,0, 7,0,0,1));
    vecs.push_back(mk(0,1,7,0,0,0,1, 7,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 7,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 7,0,0,0));

    rst_n            = 1'b0;
    bus.AClkHEn      = 1'b1;
    bus.ATick        = 1'b0;
    bus.ACfgWr       = 1'b0;
    bus.ACfgReload   = '0;
    bus.ACfgRun      = 1'b0;
    bus.ACfgPeriodic = 1'b0;
    bus.AIrqAck      = 1'b0;
    #12;
    check_outputs("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-count with irq set: immediate clear, next tick ignored
    step(mk(0,1,0,1,1,0,1, 0,0,0,1), "pre_rst_cfg");
    step(mk(1,0,0,0,0,0,1, 0,1,0,1), "pre_rst_exp");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1,0,0,0,0,0,1, 0,0,0,0), "post_rst_tick");
    step(mk(0,1,4,1,0,0,1, 4,0,0,1), "post_rst_cfg");
    step(mk(1,0,0,0,0,0,1, 3,0,0,1), "post_rst_dec");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
